// File: rtl/dmem_latency_model.sv
// Data-memory responder for the core's MREQ/ACKD_n data bus. It acks each request after a fixed
// latency, holds a big-endian byte store, reports alignment and range faults, and decodes the console and exit MMIO addresses.
module dmem_latency_model #(
  parameter int unsigned LATENCY     = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0800_0000,
  parameter int unsigned DEPTH_BYTES = 65536,
  parameter logic [31:0] STDOUT_ADDR = 32'hf000_0000,
  parameter logic [31:0] EXIT_ADDR   = 32'hff00_0000,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MREQ,
  input  logic        WRITE,
  input  logic [1:0]  SIZE,
  input  logic [31:0] DAD,
  input  logic [31:0] WDT,
  output logic [31:0] RDT,
  output logic        ACKD_n,
  output logic        STDOUT_VALID,
  output logic [7:0]  STDOUT_CHAR,
  output logic        EXIT,
  output logic        ERR
);

  localparam int          IW       = $clog2(DEPTH_BYTES);
  localparam logic [1:0]  ST_IDLE  = 2'd0;
  localparam logic [1:0]  ST_WAIT  = 2'd1;
  localparam logic [1:0]  ST_ACK   = 2'd2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + 33'(DEPTH_BYTES);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ack_entry;

  logic        wr_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q;

  logic        req_wr;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic [31:0] lo_addr;
  logic [2:0]  nbytes;
  logic [32:0] lo_ext, hi_ext;
  logic        in_range, is_stdout, is_exit, mmio_wr, misaligned, fault;

  logic [31:0]     lane_off [4];
  logic [IW-1:0]   lane_idx [4];
  logic [3:0][7:0] wbyte;
  logic [3:0]      wen;
  logic            mem_we;
  logic [31:0]     rdata;
  logic            unused_bits;

  logic [31:0] rdt_q;
  logic        err_q, stdout_valid_q, exit_q;
  logic [7:0]  stdout_char_q;

  logic [7:0] mem [DEPTH_BYTES];

  // NOTE: every always_comb assigns all of its outputs first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (MREQ) begin
          if (LATENCY == 1) begin
            state_d = ST_ACK;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == 4'd1) begin
          state_d = ST_ACK;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign ack_entry = (state_d == ST_ACK);

  // With LATENCY==1 the ack is decided on the capture edge, so the live bus is used in IDLE.
  always_comb begin
    if (state_q == ST_IDLE) begin
      req_wr    = WRITE;
      req_size  = SIZE;
      req_addr  = DAD;
      req_wdata = WDT;
    end else begin
      req_wr    = wr_q;
      req_size  = size_q;
      req_addr  = addr_q;
      req_wdata = wdata_q;
    end
  end

  // Lowest byte touched. Half and byte accesses are mirrored within their word.
  always_comb begin
    lo_addr = req_addr;
    nbytes  = 3'd4;
    case (req_size)
      2'b00: begin
        lo_addr = req_addr;
        nbytes  = 3'd4;
      end
      2'b01: begin
        lo_addr = {req_addr[31:2], 2'b10} - {30'd0, req_addr[1:0]};
        nbytes  = 3'd2;
      end
      default: begin
        lo_addr = {req_addr[31:2], 2'b11} - {30'd0, req_addr[1:0]};
        nbytes  = 3'd1;
      end
    endcase
  end

  assign lo_ext     = {1'b0, lo_addr};
  assign hi_ext     = lo_ext + {30'd0, nbytes};
  assign in_range   = (lo_ext >= {1'b0, BASE_ADDR}) && (hi_ext <= LIMIT);
  assign is_stdout  = (req_addr == STDOUT_ADDR);
  assign is_exit    = (req_addr == EXIT_ADDR);
  assign mmio_wr    = req_wr && (is_stdout || is_exit);
  assign misaligned = ((req_size == 2'b00) && (req_addr[1:0] != 2'b00)) ||
                      ((req_size == 2'b01) && req_addr[0]);
  assign fault      = misaligned || (!mmio_wr && !in_range) ||
                      (!req_wr && (is_stdout || is_exit)) ||
                      (req_wr && is_stdout && !req_size[1]);

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      lane_off[k] = lo_addr - BASE_ADDR + 32'(k);
      lane_idx[k] = lane_off[k][IW-1:0];
    end
  end

  assign unused_bits = ^{lane_off[0][31:IW], lane_off[1][31:IW],
                         lane_off[2][31:IW], lane_off[3][31:IW]};

  always_comb begin
    rdata = '0;
    case (req_size)
      2'b00:   rdata = {mem[lane_idx[0]], mem[lane_idx[1]], mem[lane_idx[2]], mem[lane_idx[3]]};
      2'b01:   rdata = {16'h0000, mem[lane_idx[0]], mem[lane_idx[1]]};
      default: rdata = {24'h000000, mem[lane_idx[0]]};
    endcase
    if (req_wr || fault) begin
      rdata = '0;
    end
  end

  // The store data is laid out most significant byte first, matching the read path.
  always_comb begin
    wbyte = '0;
    wen   = '0;
    case (req_size)
      2'b00: begin
        wbyte[0] = req_wdata[31:24];
        wbyte[1] = req_wdata[23:16];
        wbyte[2] = req_wdata[15:8];
        wbyte[3] = req_wdata[7:0];
        wen      = 4'b1111;
      end
      2'b01: begin
        wbyte[0] = req_wdata[15:8];
        wbyte[1] = req_wdata[7:0];
        wen      = 4'b0011;
      end
      default: begin
        wbyte[0] = req_wdata[7:0];
        wen      = 4'b0001;
      end
    endcase
  end

  // A store that lands while rst is held would otherwise still commit on the capture edge.
  assign mem_we = rst && ack_entry && req_wr && !fault && !is_stdout && !is_exit;

  // NOTE: flops use non-blocking <= so every update in the block sees the pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= 4'd0;
      wr_q           <= 1'b0;
      size_q         <= 2'b00;
      addr_q         <= '0;
      wdata_q        <= '0;
      rdt_q          <= '0;
      err_q          <= 1'b0;
      stdout_valid_q <= 1'b0;
      stdout_char_q  <= '0;
      exit_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      err_q          <= 1'b0;
      stdout_valid_q <= 1'b0;
      if (state_q == ST_IDLE && MREQ) begin
        wr_q    <= WRITE;
        size_q  <= SIZE;
        addr_q  <= DAD;
        wdata_q <= WDT;
      end
      if (ack_entry) begin
        rdt_q <= rdata;
        err_q <= fault;
        if (req_wr && is_stdout && !fault) begin
          stdout_valid_q <= 1'b1;
          stdout_char_q  <= req_wdata[7:0];
        end
        if (req_wr && is_exit && !fault) begin
          exit_q <= 1'b1;
        end
      end
    end
  end

  // NOTE: the byte store is left out of reset on purpose, because its contents must survive rst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int k = 0; k < 4; k++) begin
        if (wen[k]) begin
          mem[lane_idx[k]] <= wbyte[k];
        end
      end
    end
  end

  assign ACKD_n       = (state_q != ST_ACK);
  assign RDT          = rdt_q;
  assign ERR          = err_q;
  assign STDOUT_VALID = stdout_valid_q;
  assign STDOUT_CHAR  = stdout_char_q;
  assign EXIT         = exit_q;

endmodule
